leddecoder: RTL and testbench

LEDDECODER -- requirements
Module: leddecoder

---
 rtl/leddisplay_pkg.sv | 37 +++
 rtl/seg_decode.sv | 34 +++
 rtl/leddecoder.sv | 145 ++++++++++++++
 tb/tb_leddecoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leddisplay_pkg.sv
// Shared constants for the multiplexed LED display path: FSM encoding,
// seven-segment patterns (a..g on bits [6:0]) and digit-strobe one-hots.
package leddisplay_pkg;

  localparam logic [0:0] ST_SYNC    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h0D;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  localparam logic [3:0] SEL_D0 = 4'b1000;
  localparam logic [3:0] SEL_D1 = 4'b0100;
  localparam logic [3:0] SEL_D2 = 4'b0010;
  localparam logic [3:0] SEL_D3 = 4'b0001;

  typedef logic [1:0] pos_t;

  // Position 0 is the most significant digit.
  function automatic logic [3:0] sel_for_pos(input pos_t p);
    return SEL_D0 >> p;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
module seg_decode
  import leddisplay_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_ok
);

  always_comb begin
    o_nibble = 4'h0;
    o_ok     = 1'b1;
    case (i_pattern)
      SEG_0: o_nibble = 4'h0;
      SEG_1: o_nibble = 4'h1;
      SEG_2: o_nibble = 4'h2;
      SEG_3: o_nibble = 4'h3;
      SEG_4: o_nibble = 4'h4;
      SEG_5: o_nibble = 4'h5;
      SEG_6: o_nibble = 4'h6;
      SEG_7: o_nibble = 4'h7;
      SEG_8: o_nibble = 4'h8;
      SEG_9: o_nibble = 4'h9;
      SEG_A: o_nibble = 4'hA;
      SEG_B: o_nibble = 4'hB;
      SEG_C: o_nibble = 4'hC;
      SEG_D: o_nibble = 4'hD;
      SEG_E: o_nibble = 4'hE;
      SEG_F: o_nibble = 4'hF;
      default: o_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/leddecoder.sv
// Recovers a 16-bit value from a multiplexed 4-digit seven-segment stream.
//   state   | meaning
//   SYNC    | waiting for a 1000 strobe carrying a valid pending code
//   COLLECT | digits 0..pos-1 captured in shadow, expecting strobe for pos
module leddecoder
  import leddisplay_pkg::*;
#(
  parameter int IDLE_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  digitcode,
  input  logic [3:0]  selectors,
  output logic [15:0] value,
  output logic        valid,
  output logic        err
);

  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_LIMIT);

  logic [0:0]    r_state;
  pos_t          r_pos;
  logic [6:0]    r_pend_code;
  logic          r_pend_flag;
  logic [IW-1:0] r_idle;
  logic [15:0]   r_shadow;
  logic [15:0]   r_value;
  logic          r_valid;
  logic          r_err;

  logic [6:0]  w_new_code;
  logic        w_has_code;
  logic        w_strobe;
  logic        w_onehot;
  logic [3:0]  w_expected;
  logic [3:0]  w_nibble;
  logic        w_pat_ok;
  logic        w_code_ok;
  logic [15:0] w_shadow_next;

  // Decimal point is dropped before anything looks at the code.
  assign w_new_code = 7'((digitcode & 8'hFE) >> 1);
  assign w_has_code = |w_new_code;
  assign w_strobe   = |selectors;
  assign w_onehot   = w_strobe && ((selectors & (selectors - 4'd1)) == 4'd0);
  assign w_expected = sel_for_pos(r_pos);
  assign w_code_ok  = r_pend_flag && w_pat_ok;

  seg_decode u_seg_decode (
    .i_pattern (r_pend_code),
    .o_nibble  (w_nibble),
    .o_ok      (w_pat_ok)
  );

  always_comb begin
    w_shadow_next = r_shadow;
    case (r_pos)
      2'd0: w_shadow_next[15:12] = w_nibble;
      2'd1: w_shadow_next[11:8]  = w_nibble;
      2'd2: w_shadow_next[7:4]   = w_nibble;
      default: w_shadow_next[3:0] = w_nibble;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_SYNC;
      r_pos       <= 2'd0;
      r_pend_code <= 7'h00;
      r_pend_flag <= 1'b0;
      r_idle      <= '0;
      r_shadow    <= 16'h0000;
      r_value     <= 16'h0000;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      // A strobe always pairs with the code pending before this cycle.
      if (w_has_code) begin
        r_pend_code <= w_new_code;
        r_pend_flag <= 1'b1;
      end else if (w_strobe) begin
        r_pend_flag <= 1'b0;
      end

      case (r_state)
        ST_SYNC: begin
          if (selectors == SEL_D0 && w_code_ok) begin
            r_shadow <= {w_nibble, 12'h000};
            r_pos    <= 2'd1;
            r_idle   <= IDLE_LOAD;
            r_state  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_strobe) begin
            if (selectors == SEL_D0) begin
              r_err <= 1'b1;
              if (w_code_ok) begin
                r_shadow <= {w_nibble, 12'h000};
                r_pos    <= 2'd1;
                r_idle   <= IDLE_LOAD;
              end else begin
                r_shadow <= 16'h0000;
                r_pos    <= 2'd0;
                r_state  <= ST_SYNC;
              end
            end else if (!w_onehot || selectors != w_expected || !w_code_ok) begin
              r_err    <= 1'b1;
              r_shadow <= 16'h0000;
              r_pos    <= 2'd0;
              r_state  <= ST_SYNC;
            end else if (r_pos == 2'd3) begin
              r_value  <= w_shadow_next;
              r_valid  <= 1'b1;
              r_shadow <= 16'h0000;
              r_pos    <= 2'd0;
              r_state  <= ST_SYNC;
            end else begin
              r_shadow <= w_shadow_next;
              r_pos    <= r_pos + 2'd1;
              r_idle   <= IDLE_LOAD;
            end
          end else if (r_idle == IW'(1)) begin
            r_err    <= 1'b1;
            r_shadow <= 16'h0000;
            r_pos    <= 2'd0;
            r_state  <= ST_SYNC;
          end else begin
            r_idle <= r_idle - IW'(1);
          end
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign value = r_value;
  assign valid = r_valid;
  assign err   = r_err;

endmodule

// File: tb/tb_leddecoder.sv
// Directed and randomized checks of leddecoder against a frame-level model.
module tb_leddecoder;

  localparam int IDLE_LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dc;
  logic [3:0]  sel;
  logic [15:0] value;
  logic        valid;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int last_valid_cyc = -1;
  int prev_valid_cyc = -1;

  // Model state: pending pattern (-1 = none) and digits captured so far.
  int          m_pend;
  int          m_frame[$];
  int          m_idle;
  logic [15:0] m_value;
  logic        m_valid;
  logic        m_err;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

  leddecoder #(.IDLE_LIMIT(IDLE_LIMIT)) dut (
    .clock     (clk),
    .reset     (rst),
    .digitcode (dc),
    .selectors (sel),
    .value     (value),
    .valid     (valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic int lookup(input int pat);
    for (int i = 0; i < 16; i++)
      if (pat == int'(seg_tab[i])) return i;
    return -1;
  endfunction

  function automatic logic [7:0] pat(input int nib, input logic dp);
    logic [6:0] s;
    s = seg_tab[nib];
    return {s, dp};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [7:0] d, input logic [3:0] s);
    int code;
    int nib;
    int want;
    code = int'(d[7:1]);
    nib  = (m_pend >= 0) ? lookup(m_pend) : -1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (s != 4'd0) begin
      if (m_frame.size() == 0) begin
        if (s == 4'b1000 && nib >= 0) begin
          m_frame.push_back(nib);
          m_idle = 0;
        end
      end else begin
        want = m_frame.size();
        m_idle = 0;
        if (s == 4'b1000) begin
          m_err = 1'b1;
          m_frame.delete();
          if (nib >= 0) m_frame.push_back(nib);
        end else if ($countones(s) != 1 || s != (4'b1000 >> want) || nib < 0) begin
          m_err = 1'b1;
          m_frame.delete();
        end else begin
          m_frame.push_back(nib);
          if (m_frame.size() == 4) begin
            m_value = 16'((m_frame[0] << 12) | (m_frame[1] << 8) | (m_frame[2] << 4) | m_frame[3]);
            m_valid = 1'b1;
            m_frame.delete();
          end
        end
      end
    end else if (m_frame.size() > 0) begin
      m_idle++;
      if (m_idle == IDLE_LIMIT) begin
        m_err = 1'b1;
        m_frame.delete();
      end
    end
    if (code != 0) m_pend = code;
    else if (s != 4'd0) m_pend = -1;
  endtask

  task automatic cyc(input logic [7:0] d, input logic [3:0] s);
    dc  = d;
    sel = s;
    model_step(d, s);
    @(posedge clk);
    #1;
    cyc_n++;
    check("valid", {15'b0, valid}, {15'b0, m_valid});
    check("err",   {15'b0, err},   {15'b0, m_err});
    check("value", value, m_value);
    if (valid === 1'b1) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc_n;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    dc  = 8'h00;
    sel = 4'h0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_pend  = -1;
    m_frame.delete();
    m_idle  = 0;
    m_value = 16'h0000;
    m_valid = 1'b0;
    m_err   = 1'b0;
    check("rst_valid", {15'b0, valid}, 16'd0);
    check("rst_err",   {15'b0, err},   16'd0);
    check("rst_value", value, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(8'h00, 4'h0);
  endtask

  task automatic send_frame(input logic [15:0] v, input bit rnd_dp);
    for (int i = 0; i < 4; i++) begin
      cyc(pat(int'((v >> (12 - 4 * i)) & 16'hF), rnd_dp ? 1'($urandom) : 1'b0), 4'h0);
      cyc(8'h00, 4'(4'b1000 >> i));
    end
  endtask

  initial begin
    do_reset(3);

    // Reference frame 0x1234 in driver bit order.
    cyc(8'h60, 4'h0); cyc(8'h00, 4'b1000);
    cyc(8'hDA, 4'h0); cyc(8'h00, 4'b0100);
    cyc(8'hF2, 4'h0); cyc(8'h00, 4'b0010);
    cyc(8'h66, 4'h0); cyc(8'h00, 4'b0001);
    check("r027_valid", {15'b0, valid}, 16'd1);
    check("r027_value", value, 16'h1234);
    idle(2);

    // Invalid third code.
    cyc(8'h60, 4'h0); cyc(8'h00, 4'b1000);
    cyc(8'hDA, 4'h0); cyc(8'h00, 4'b0100);
    cyc(8'h02, 4'h0); cyc(8'h00, 4'b0010);
    check("r028_err", {15'b0, err}, 16'd1);
    check("r028_hold", value, 16'h1234);
    cyc(8'h66, 4'h0); cyc(8'h00, 4'b0001);
    send_frame(16'hFFFF, 1'b0);
    check("r028_next", value, 16'hFFFF);

    // Skipped position.
    cyc(8'h60, 4'h0); cyc(8'h00, 4'b1000);
    cyc(8'hDA, 4'h0); cyc(8'h00, 4'b0010);
    check("r029_err", {15'b0, err}, 16'd1);
    send_frame(16'h5678, 1'b0);
    check("r029_next", value, 16'h5678);

    // Reset mid-frame.
    cyc(pat(10, 1'b0), 4'h0); cyc(8'h00, 4'b1000);
    cyc(pat(11, 1'b0), 4'h0); cyc(8'h00, 4'b0100);
    do_reset(1);
    send_frame(16'hABCD, 1'b0);
    check("r030_next", value, 16'hABCD);

    // Idle timeout and its near miss.
    cyc(pat(1, 1'b0), 4'h0); cyc(8'h00, 4'b1000);
    idle(15);
    check("r031_no_err_15", {15'b0, err}, 16'd0);
    cyc(8'h00, 4'h0);
    check("r031_err_16", {15'b0, err}, 16'd1);
    cyc(pat(2, 1'b0), 4'h0); cyc(8'h00, 4'b1000);
    idle(13);
    cyc(pat(3, 1'b0), 4'h0); cyc(8'h00, 4'b0100);
    check("r031_saved", {15'b0, err}, 16'd0);
    idle(20);

    // Back-to-back frames.
    send_frame(16'h0000, 1'b0);
    check("r032_first", value, 16'h0000);
    send_frame(16'h9F8E, 1'b0);
    check("r032_second", value, 16'h9F8E);
    check("r032_gap", 16'(last_valid_cyc - prev_valid_cyc), 16'd8);

    // New code presented alongside the strobe of the previous one.
    cyc(pat(1, 1'b0), 4'h0);
    cyc(pat(2, 1'b1), 4'b1000);
    cyc(pat(3, 1'b0), 4'b0100);
    cyc(pat(4, 1'b1), 4'b0010);
    cyc(8'h00, 4'b0001);
    check("overlap_value", value, 16'h1234);
    idle(3);

    for (int it = 0; it < 400; it++) begin
      int r;
      logic [7:0] d;
      r = int'($urandom_range(0, 19));
      if (r < 11) begin
        idle(int'($urandom_range(0, 2)));
        send_frame(16'($urandom), 1'b1);
      end else if (r < 14) begin
        d = 8'($urandom);
        if (d[7:1] == 7'd0) d = 8'h00;
        cyc(d, 4'($urandom_range(0, 15)));
      end else if (r < 16) begin
        idle(int'($urandom_range(10, 20)));
      end else if (r < 19) begin
        logic [15:0] v;
        v = 16'($urandom);
        cyc(pat(int'(v[15:12]), 1'($urandom)), 4'h0);
        cyc(pat(int'(v[11:8]),  1'($urandom)), 4'b1000);
        cyc(pat(int'(v[7:4]),   1'($urandom)), 4'b0100);
        cyc(pat(int'(v[3:0]),   1'($urandom)), 4'b0010);
        cyc(8'h00, 4'b0001);
      end else begin
        do_reset(1);
      end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
